shift_right_seq: RTL and testbench

- Multi-cycle right-shift unit for the datapath ALU. Serves SRL/SRA/SRLV/SRAV; complements the combinational left-shift path.
- Shifts a 32-bit operand right by 0-31 positions, one bit per clock, with logical or arithmetic fill.
- Uses a start/busy/done handshake so the control unit can stall while a shift is in flight.

---
 rtl/datapath_pkg.sv | 14 +
 rtl/shift_right1.sv | 16 +
 rtl/shift_right_seq.sv | 93 +++++++++
 tb/tb_shift_right_seq.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared datapath definitions: operand widths and the
// multi-cycle shifter state encoding.
package datapath_pkg;

    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_right1.sv
// Single-bit right-shift step with logical or sign fill.
// Purely combinational; sequenced by shift_right_seq.
module shift_right1 #(
    parameter int WIDTH = datapath_pkg::WIDTH
) (
    input  logic [WIDTH-1:0] in,
    input  logic             arith,
    output logic [WIDTH-1:0] out
);

    logic fill;

    assign fill = arith & in[WIDTH-1];
    assign out  = {fill, in[WIDTH-1:1]};

endmodule

// File: rtl/shift_right_seq.sv
// Multi-cycle right shifter: one bit per clock, start/busy/done
// handshake so the controller can stall while a shift is in flight.
module shift_right_seq #(
    parameter int WIDTH   = datapath_pkg::WIDTH,
    parameter int SHAMT_W = datapath_pkg::SHAMT_W
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   in,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               arith,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   out
);

    import datapath_pkg::*;

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   sreg;
    logic [WIDTH-1:0]   step;
    logic [SHAMT_W-1:0] cnt;
    logic               mode;
    logic               last;

    shift_right1 #(
        .WIDTH(WIDTH)
    ) u_step (
        .in   (sreg),
        .arith(mode),
        .out  (step)
    );

    assign last = (cnt == SHAMT_W'(1));
    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (shamt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // out is loaded on the edge that enters DONE, so it is
    // valid during the done pulse and held afterwards.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
            mode  <= 1'b0;
            out   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        sreg <= in;
                        cnt  <= shamt;
                        mode <= arith;
                        if (shamt == '0) begin
                            out <= in;
                        end
                    end
                end
                SHIFT: begin
                    sreg <= step;
                    cnt  <= cnt - SHAMT_W'(1);
                    if (last) begin
                        out <= step;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_right_seq.sv
// Directed bench for shift_right_seq: vector table plus
// hand-written sequences for ignored starts and mid-shift reset.
module tb_shift_right_seq;

    logic        Clk;
    logic        Reset;
    logic        start;
    logic [31:0] in;
    logic [4:0]  shamt;
    logic        arith;
    logic        busy;
    logic        done;
    logic [31:0] dout;

    int n_run;
    int n_fail;

    shift_right_seq dut (
        .Clk  (Clk),
        .Reset(Reset),
        .start(start),
        .in   (in),
        .shamt(shamt),
        .arith(arith),
        .busy (busy),
        .done (done),
        .out  (dout)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] in;
        logic [4:0]  shamt;
        logic        arith;
        logic [31:0] exp_out;
        int          exp_cyc;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h",
                     name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Issue one operation and observe it to completion.
    task automatic run_op(input vec_t v, input string name);
        int busy_n;
        int done_n;
        int done_cyc;
        logic [31:0] out_at_done;
        busy_n   = 0;
        done_n   = 0;
        done_cyc = -1;
        out_at_done = '0;
        in    = v.in;
        shamt = v.shamt;
        arith = v.arith;
        start = 1'b1;
        tick();
        start = 1'b0;
        in    = 32'h5A5A_5A5A;
        shamt = 5'd7;
        arith = ~v.arith;
        for (int c = 1; c <= 40; c++) begin
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_cyc < 0) begin
                    done_cyc    = c;
                    out_at_done = dout;
                end
            end
            if (!busy && c > 1) break;
            tick();
        end
        check({name, " done_cycle"}, done_cyc, v.exp_cyc);
        check({name, " out"}, out_at_done, v.exp_out);
        check({name, " busy_cycles"}, busy_n, v.exp_cyc);
        check({name, " done_pulses"}, done_n, 1);
        check({name, " out_hold"}, dout, v.exp_out);
    endtask

    initial begin
        vec_t v;
        n_run  = 0;
        n_fail = 0;
        Reset  = 1'b1;
        start  = 1'b0;
        in     = '0;
        shamt  = '0;
        arith  = 1'b0;

        vecs[0] = '{32'h8000_0010, 5'd4,  1'b0, 32'h0800_0001, 5};
        vecs[1] = '{32'h8000_0010, 5'd4,  1'b1, 32'hF800_0001, 5};
        vecs[2] = '{32'hDEAD_BEEF, 5'd0,  1'b1, 32'hDEAD_BEEF, 1};
        vecs[3] = '{32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF, 32};
        vecs[4] = '{32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001, 32};
        vecs[5] = '{32'h1234_5678, 5'd8,  1'b1, 32'h0012_3456, 9};

        tick();
        tick();
        Reset = 1'b0;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset out", dout, 32'd0);

        foreach (vecs[i]) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
            tick();
        end

        // Starts during SHIFT (cycle 2) and DONE (cycle 5) are ignored.
        begin
            int done_n;
            int done_cyc;
            int busy_late;
            logic [31:0] o5;
            done_n    = 0;
            done_cyc  = -1;
            busy_late = 0;
            o5        = '0;
            in    = 32'h0000_00F0;
            shamt = 5'd4;
            arith = 1'b0;
            start = 1'b1;
            tick();
            start = 1'b0;
            for (int c = 1; c <= 9; c++) begin
                if (done) begin
                    done_n++;
                    done_cyc = c;
                    o5 = dout;
                end
                if (c > 5 && busy) busy_late++;
                if (c == 2 || c == 5) begin
                    in    = 32'h1;
                    shamt = 5'd1;
                    start = 1'b1;
                end else begin
                    start = 1'b0;
                end
                tick();
            end
            start = 1'b0;
            check("ign done_pulses", done_n, 1);
            check("ign done_cycle", done_cyc, 5);
            check("ign out", o5, 32'h0000_000F);
            check("ign no_second_op", busy_late, 0);
            check("ign out_hold", dout, 32'h0000_000F);
        end

        // Reset asserted in cycle 3 aborts the shift.
        in    = 32'hFFFF_0000;
        shamt = 5'd10;
        arith = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst out", dout, 32'd0);
        tick();
        check("rst stays_idle", 32'(busy), 32'd0);

        v = '{32'h0000_0400, 5'd10, 1'b0, 32'h0000_0001, 11};
        run_op(v, "post_rst");

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
